// File: rtl/sevseg_scan_ctrl_n.sv
// Time-multiplexed common-anode seven-segment scanner with frame-synchronous
// value loading, leading-zero suppression, PWM brightness and anti-ghost guard.
module sevseg_scan_ctrl_n #(
  parameter int NUM_DIGITS = 8,
  parameter int SLOT_LOG2  = 9,
  parameter int PWM_BITS   = 4,
  parameter int GUARD_CYC  = 2
) (
  input  logic                    clk_5mhz0d,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] hex_val,
  input  logic [NUM_DIGITS-1:0]   dp_val,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic [PWM_BITS-1:0]     brightness,
  input  logic                    load,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [SLOT_LOG2-1:0]    slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]        dig_idx_q, dig_idx_d;
  logic                    pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] stage_hex_q, stage_hex_d, shadow_hex_q, shadow_hex_d;
  logic [NUM_DIGITS-1:0]   stage_dp_q, stage_dp_d, shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0]   stage_en_q, stage_en_d, shadow_en_q, shadow_en_d;
  logic [NUM_DIGITS-1:0]   lz_mask_q, lz_mask_d;
  logic [6:0]              seg_n_q, seg_n_d;
  logic                    dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
  logic                    frame_tick_q, frame_tick_d;

  logic                    slot_wrap, frame_bnd, lit, zero_run;
  logic [3:0]              cur_nib;

  function automatic logic [6:0] hex_to_seg_n(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg_n = 7'b1000000;
      4'h1: hex_to_seg_n = 7'b1111001;
      4'h2: hex_to_seg_n = 7'b0100100;
      4'h3: hex_to_seg_n = 7'b0110000;
      4'h4: hex_to_seg_n = 7'b0011001;
      4'h5: hex_to_seg_n = 7'b0010010;
      4'h6: hex_to_seg_n = 7'b0000010;
      4'h7: hex_to_seg_n = 7'b1111000;
      4'h8: hex_to_seg_n = 7'b0000000;
      4'h9: hex_to_seg_n = 7'b0010000;
      4'hA: hex_to_seg_n = 7'b0001000;
      4'hB: hex_to_seg_n = 7'b0000011;
      4'hC: hex_to_seg_n = 7'b1000110;
      4'hD: hex_to_seg_n = 7'b0100001;
      4'hE: hex_to_seg_n = 7'b0000110;
      default: hex_to_seg_n = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    slot_wrap  = &slot_cnt_q;
    frame_bnd  = slot_wrap && (dig_idx_q == LAST_IDX);
    slot_cnt_d = slot_cnt_q + 1'b1;
    dig_idx_d  = dig_idx_q;
    if (slot_wrap) dig_idx_d = (dig_idx_q == LAST_IDX) ? '0 : dig_idx_q + 1'b1;

    stage_hex_d  = stage_hex_q;
    stage_dp_d   = stage_dp_q;
    stage_en_d   = stage_en_q;
    shadow_hex_d = shadow_hex_q;
    shadow_dp_d  = shadow_dp_q;
    shadow_en_d  = shadow_en_q;
    pending_d    = pending_q;
    if (frame_bnd && load) begin
      // Coincident load bypasses staging so it is not delayed a whole frame.
      shadow_hex_d = hex_val;
      shadow_dp_d  = dp_val;
      shadow_en_d  = digit_en;
      pending_d    = 1'b0;
    end else if (frame_bnd && pending_q) begin
      shadow_hex_d = stage_hex_q;
      shadow_dp_d  = stage_dp_q;
      shadow_en_d  = stage_en_q;
      pending_d    = 1'b0;
    end else if (load) begin
      stage_hex_d = hex_val;
      stage_dp_d  = dp_val;
      stage_en_d  = digit_en;
      pending_d   = 1'b1;
    end

    // Zero-run from the most significant digit; blank_lz is applied live.
    lz_mask_d = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run     = zero_run && (shadow_hex_d[4*i +: 4] == 4'h0) && !shadow_dp_d[i];
      lz_mask_d[i] = zero_run;
    end

    cur_nib = shadow_hex_q[{dig_idx_q, 2'b00} +: 4];
    lit = shadow_en_q[dig_idx_q]
       && !(blank_lz && lz_mask_q[dig_idx_q])
       && (slot_cnt_q >= SLOT_LOG2'(GUARD_CYC))
       && (slot_cnt_q[SLOT_LOG2-1 -: PWM_BITS] <= brightness);

    seg_n_d = 7'h7F;
    dp_n_d  = 1'b1;
    an_n_d  = '1;
    if (lit) begin
      seg_n_d           = hex_to_seg_n(cur_nib);
      dp_n_d            = !shadow_dp_q[dig_idx_q];
      an_n_d[dig_idx_q] = 1'b0;
    end
    frame_tick_d = frame_bnd;
  end

  always_ff @(posedge clk_5mhz0d) begin
    if (!rst_n) begin
      slot_cnt_q   <= '0;
      dig_idx_q    <= '0;
      pending_q    <= 1'b0;
      stage_hex_q  <= '0;
      stage_dp_q   <= '0;
      stage_en_q   <= '0;
      shadow_hex_q <= '0;
      shadow_dp_q  <= '0;
      shadow_en_q  <= '0;
      lz_mask_q    <= '0;
      seg_n_q      <= 7'h7F;
      dp_n_q       <= 1'b1;
      an_n_q       <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      dig_idx_q    <= dig_idx_d;
      pending_q    <= pending_d;
      stage_hex_q  <= stage_hex_d;
      stage_dp_q   <= stage_dp_d;
      stage_en_q   <= stage_en_d;
      shadow_hex_q <= shadow_hex_d;
      shadow_dp_q  <= shadow_dp_d;
      shadow_en_q  <= shadow_en_d;
      lz_mask_q    <= lz_mask_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      an_n_q       <= an_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign an_n       = an_n_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sevseg_scan_ctrl_n.sv
// Randomized and directed bench for sevseg_scan_ctrl_n against a time-based
// reference model (digit/slot derived from elapsed clocks since reset).
`timescale 1ns/1ps
module tb_sevseg_scan_ctrl_n;

  localparam int N     = 8;
  localparam int SL2   = 9;
  localparam int PB    = 4;
  localparam int GC    = 2;
  localparam int SLOT  = 1 << SL2;
  localparam int FRAME = N * SLOT;

  logic          clk_5mhz0d = 1'b0;
  logic          rst_n;
  logic [4*N-1:0] hex_val;
  logic [N-1:0]  dp_val, digit_en;
  logic          blank_lz;
  logic [PB-1:0] brightness;
  logic          load;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic [N-1:0]  an_n;
  logic          frame_tick;

  always #100 clk_5mhz0d = ~clk_5mhz0d;

  sevseg_scan_ctrl_n #(.NUM_DIGITS(N), .SLOT_LOG2(SL2), .PWM_BITS(PB), .GUARD_CYC(GC)) dut (
    .clk_5mhz0d(clk_5mhz0d), .rst_n(rst_n), .hex_val(hex_val), .dp_val(dp_val),
    .digit_en(digit_en), .blank_lz(blank_lz), .brightness(brightness), .load(load),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .frame_tick(frame_tick)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: elapsed clocks since reset plus shown/staged values.
  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [3:0] m_hex [N];
  logic [3:0] m_sthex [N];
  bit         m_dp [N], m_en [N], m_stdp [N], m_sten [N];
  bit         m_pend;
  int         t;
  int         run_len, last_run;

  function automatic bit lz_blank(input int d);
    if (!blank_lz || d == 0) return 1'b0;
    for (int j = d; j < N; j++)
      if (m_hex[j] != 4'h0 || m_dp[j]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [16:0] predict();
    int slot, d;
    bit lit;
    logic [N-1:0] an;
    if (!rst_n) return {1'b0, 1'b1, 7'h7F, 8'hFF};
    slot = t % SLOT;
    d    = (t / SLOT) % N;
    lit  = m_en[d] && !lz_blank(d) && slot >= GC && (slot / (SLOT >> PB)) <= int'(brightness);
    an   = '1;
    if (lit) an[d] = 1'b0;
    return {((t % FRAME) == FRAME - 1), (lit ? !m_dp[d] : 1'b1),
            (lit ? seg_tab[m_hex[d]] : 7'h7F), an};
  endfunction

  task automatic model_update();
    bit bnd;
    if (!rst_n) begin
      for (int j = 0; j < N; j++) begin
        m_hex[j] = 0; m_sthex[j] = 0; m_dp[j] = 0; m_en[j] = 0; m_stdp[j] = 0; m_sten[j] = 0;
      end
      m_pend = 0;
      t = 0;
      return;
    end
    bnd = (t % FRAME) == FRAME - 1;
    if (bnd && (load || m_pend)) begin
      for (int j = 0; j < N; j++) begin
        m_hex[j] = load ? hex_val[4*j +: 4] : m_sthex[j];
        m_dp[j]  = load ? dp_val[j]   : m_stdp[j];
        m_en[j]  = load ? digit_en[j] : m_sten[j];
      end
      m_pend = 0;
    end else if (load) begin
      for (int j = 0; j < N; j++) begin
        m_sthex[j] = hex_val[4*j +: 4]; m_stdp[j] = dp_val[j]; m_sten[j] = digit_en[j];
      end
      m_pend = 1;
    end
    t++;
  endtask

  task automatic step();
    logic [16:0] exp;
    exp = predict();
    @(posedge clk_5mhz0d);
    #1;
    check_val("pins", {15'd0, frame_tick, dp_n, seg_n, an_n}, {15'd0, exp});
    if (an_n != '1) run_len++;
    else begin
      if (run_len > 0) last_run = run_len;
      run_len = 0;
    end
    model_update();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_load();
    load = 1'b1;
    $display("load t=%0d hex=%h dp=%h en=%h blz=%0d bright=%h", t, hex_val, dp_val, digit_en, blank_lz, brightness);
    step();
    load = 1'b0;
  endtask

  task automatic wait_tick();
    int c = 0;
    while (!frame_tick && c < FRAME + 8) begin step(); c++; end
    check_val("tick_wait", {31'd0, frame_tick}, 32'd1);
  endtask

  task automatic wait_pos(input int d, input int s);
    int c = 0;
    while (!(((t / SLOT) % N) == d && (t % SLOT) == s) && c < FRAME + 8) begin step(); c++; end
    check_val("pos_wait", t, 32'(((t / FRAME) * FRAME) + d * SLOT + s));
  endtask

  initial begin
    int c;
    bit seen;
    rst_n = 0; load = 0; hex_val = '0; dp_val = '0; digit_en = '0;
    blank_lz = 0; brightness = 4'hF; run_len = 0; last_run = 0; t = 0;

    // Reset, then measure distance to first frame_tick.
    run(10);
    check_val("reset_an", {24'd0, an_n}, 32'hFF);
    rst_n = 1;
    c = 0; seen = 0;
    while (!seen && c < FRAME + 100) begin step(); c++; seen = frame_tick; end
    check_val("first_tick", c, FRAME);

    // Scan and decode with all digits enabled at full brightness.
    hex_val = 32'h0123ABCD; digit_en = 8'hFF; dp_val = 0;
    pulse_load();
    wait_tick();
    run(FRAME);
    check_val("ontime_b15", last_run, 510);

    // Brightness extremes; runs of the last full slot are measured.
    brightness = 4'h0; run(3 * SLOT);
    check_val("ontime_b0", last_run, 30);
    brightness = 4'h7; run(3 * SLOT);
    check_val("ontime_b7", last_run, 254);
    brightness = 4'hF;

    // Leading-zero suppression, then a dp stopping the zero run at digit 4.
    hex_val = 32'h000000A5; blank_lz = 1;
    pulse_load(); wait_tick(); run(FRAME);
    dp_val = 8'h10;
    pulse_load(); wait_tick(); run(FRAME);

    // Tear-free mid-frame load at digit 3.
    blank_lz = 0; dp_val = 0;
    wait_pos(3, 100);
    hex_val = 32'h11111111;
    pulse_load(); wait_tick(); run(SLOT);

    // Load coincident with the frame boundary.
    wait_pos(N - 1, SLOT - 1);
    hex_val = 32'hFEDC9876; dp_val = 8'h81;
    pulse_load();
    check_val("coinc_tick", {31'd0, frame_tick}, 32'd1);
    run(FRAME);

    // Partial digit enable.
    digit_en = 8'h0F;
    pulse_load(); wait_tick(); run(FRAME);

    // Randomized loads, brightness and blanking changes.
    for (int k = 0; k < 3 * FRAME; k++) begin
      if ($urandom_range(0, 1499) == 0) begin
        hex_val  = $urandom >> (4 * $urandom_range(0, 7));
        dp_val   = ($urandom_range(0, 2) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
        digit_en = ($urandom_range(0, 1) == 0) ? 8'hFF : N'($urandom);
        blank_lz = 1'($urandom);
        pulse_load();
      end else begin
        if ($urandom_range(0, 1999) == 0) brightness = PB'($urandom);
        step();
      end
    end

    // Mid-frame reset at digit 5, then restart from digit 0.
    digit_en = 8'hFF; hex_val = 32'h76543210; blank_lz = 0; brightness = 4'hF;
    pulse_load(); wait_tick();
    wait_pos(5, 200);
    rst_n = 0;
    step();
    check_val("midrst_an", {24'd0, an_n}, 32'hFF);
    step();
    rst_n = 1;
    run(2 * SLOT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
